// File: rtl/board_pkg.sv
// Shared board geometry, colour/index types and the scan FSM state encoding.
// Used by board_scan_reader and board_addr_walker.
package board_pkg;

    localparam int unsigned MAX_SIZE = 26;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned CNT_W    = 10;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam idx_t IDX_ONE = idx_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} scan_state_t;

    function automatic idx_t clamp_size(input idx_t size);
        return (size > idx_t'(MAX_SIZE)) ? idx_t'(MAX_SIZE) : size;
    endfunction

endpackage

// File: rtl/board_addr_walker.sv
// Row-major (row, col) walker over a size x size region with load, step and
// a last-cell flag; shared with the VGA board renderer.
module board_addr_walker
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [IDX_W-1:0] size,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    logic col_wrap;

    assign col_wrap = ((col + IDX_ONE) == size);
    assign last     = col_wrap && ((row + IDX_ONE) == size);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + IDX_ONE;
            end else begin
                col <= col + IDX_ONE;
            end
        end
    end

endmodule

// File: rtl/board_scan_reader.sv
// Scans the active board region, reports uniformity (WON) and top-left match count.
// Optional BOARD_SCAN_EARLY_EXIT_EN: stop reading at the first mismatching cell.
module board_scan_reader
    import board_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [IDX_W-1:0]   SIZE,
    output logic               RD_EN,
    output logic [IDX_W-1:0]   RD_ROW,
    output logic [IDX_W-1:0]   RD_COL,
    input  logic [COLOR_W-1:0] RD_DATA,
    output logic               DONE,
    output logic               WON,
    output logic [CNT_W-1:0]   MATCH_COUNT,
    output logic [COLOR_W-1:0] REF_COLOR
);

    scan_state_t state;
    idx_t        eff_size;
    idx_t        req_size;
    logic        dvalid;
    logic        have_ref;
    logic        is_match;
    logic        abort;
    logic        accept;
    logic        walk_step;
    logic        walk_last;

    assign req_size = clamp_size(SIZE);
    assign accept   = (state == IDLE) && START && !DONE;
    assign is_match = (RD_DATA == REF_COLOR);

`ifdef BOARD_SCAN_EARLY_EXIT_EN
    assign abort = dvalid && have_ref && !is_match;
`else
    assign abort = 1'b0;
`endif

    assign walk_step = (state == SCAN) && !walk_last && !abort;

    board_addr_walker u_walker (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .load  (accept),
        .step  (walk_step),
        .size  (eff_size),
        .row   (RD_ROW),
        .col   (RD_COL),
        .last  (walk_last)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            eff_size    <= '0;
            RD_EN       <= 1'b0;
            dvalid      <= 1'b0;
            have_ref    <= 1'b0;
            DONE        <= 1'b0;
            WON         <= 1'b0;
            MATCH_COUNT <= '0;
            REF_COLOR   <= '0;
        end else begin
            // An abort also squashes the read still in flight.
            dvalid <= RD_EN && !abort;

            if (dvalid) begin
                if (!have_ref) begin
                    REF_COLOR   <= RD_DATA;
                    have_ref    <= 1'b1;
                    MATCH_COUNT <= MATCH_COUNT + CNT_ONE;
                end else if (is_match) begin
                    MATCH_COUNT <= MATCH_COUNT + CNT_ONE;
                end else begin
                    WON <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        eff_size    <= req_size;
                        WON         <= 1'b1;
                        MATCH_COUNT <= '0;
                        have_ref    <= 1'b0;
                        if (req_size == '0) begin
                            state <= FIN;
                        end else begin
                            state <= SCAN;
                            RD_EN <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (abort || walk_last) begin
                        RD_EN <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!dvalid) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                    end
                end
                FIN: begin
                    // Empty boards enter FIN with DONE low; it rises one edge later.
                    if (DONE && !START) begin
                        DONE  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_scan_reader.sv
// Directed bench for board_scan_reader: latency, results, address order, reset abort, handshake.
// Expectations follow BOARD_SCAN_EARLY_EXIT_EN when the macro is defined.
module tb_board_scan_reader;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic [4:0] SIZE = '0;
    logic       RD_EN;
    logic [4:0] RD_ROW;
    logic [4:0] RD_COL;
    logic [2:0] RD_DATA = 3'd7;
    logic       DONE;
    logic       WON;
    logic [9:0] MATCH_COUNT;
    logic [2:0] REF_COLOR;

    int total = 0;
    int bad = 0;
    int reads = 0;
    int order_err = 0;
    int exp_r = 0;
    int exp_c = 0;
    int exp_n = 0;
    int last_r = 0;
    int last_c = 0;
    int e = 0;

    logic [2:0] mem [26][26];

    board_scan_reader dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .START       (START),
        .SIZE        (SIZE),
        .RD_EN       (RD_EN),
        .RD_ROW      (RD_ROW),
        .RD_COL      (RD_COL),
        .RD_DATA     (RD_DATA),
        .DONE        (DONE),
        .WON         (WON),
        .MATCH_COUNT (MATCH_COUNT),
        .REF_COLOR   (REF_COLOR)
    );

    always #5 CLOCK = ~CLOCK;

    // Synchronous read port with junk data when not strobed, plus read-order monitor.
    always @(posedge CLOCK) begin
        if (RD_EN && RD_ROW < 5'd26 && RD_COL < 5'd26)
            RD_DATA <= mem[RD_ROW][RD_COL];
        else
            RD_DATA <= 3'd7;
        if (RD_EN) begin
            reads++;
            if (RD_ROW !== 5'(exp_r) || RD_COL !== 5'(exp_c)) order_err++;
            last_r = int'(RD_ROW);
            last_c = int'(RD_COL);
            if (exp_c + 1 == exp_n) begin
                exp_c = 0;
                exp_r++;
            end else begin
                exp_c++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [2:0] colour);
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                mem[r][c] = colour;
    endtask

    task automatic begin_scan(input logic [4:0] sz, input int n_eff);
        reads = 0;
        order_err = 0;
        exp_r = 0;
        exp_c = 0;
        exp_n = n_eff;
        SIZE = sz;
        START = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            @(posedge CLOCK);
            #1;
            edges++;
            if (DONE === 1'b1) break;
        end
    endtask

    task automatic end_scan(input string tag);
        START = 1'b0;
        @(posedge CLOCK);
        #1;
        check(tag, DONE, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, RD_EN, 0);
        check({tag, "_rd_row"}, RD_ROW, 0);
        check({tag, "_rd_col"}, RD_COL, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_won"}, WON, 0);
        check({tag, "_count"}, MATCH_COUNT, 0);
        check({tag, "_ref"}, REF_COLOR, 0);
    endtask

    initial begin
        fill(3'd0);
        repeat (2) @(posedge CLOCK);
        #1;
        check_idle_outputs("reset");
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;

        // 4x4 uniform board, then START held after DONE.
        fill(3'd2);
        begin_scan(5'd4, 4);
        wait_done(40, e);
        check("u4_latency", e, 19);
        check("u4_done", DONE, 1);
        check("u4_won", WON, 1);
        check("u4_count", MATCH_COUNT, 16);
        check("u4_ref", REF_COLOR, 2);
        check("u4_reads", reads, 16);
        check("u4_order", order_err, 0);
        check("u4_last_row", last_r, 3);
        check("u4_last_col", last_c, 3);
        repeat (3) begin
            @(posedge CLOCK);
            #1;
            check("hold_done", DONE, 1);
        end
        check("hold_no_rescan", reads, 16);
        end_scan("u4_done_fall");
        check("u4_count_held", MATCH_COUNT, 16);

        // 3x3 with the last cell different.
        fill(3'd1);
        mem[2][2] = 3'd5;
        begin_scan(5'd3, 3);
        wait_done(40, e);
`ifdef BOARD_SCAN_EARLY_EXIT_EN
        check("m33_latency_bound", (e <= 13), 1);
`else
        check("m33_latency", e, 12);
`endif
        check("m33_done", DONE, 1);
        check("m33_won", WON, 0);
        check("m33_count", MATCH_COUNT, 8);
        check("m33_ref", REF_COLOR, 1);
        end_scan("m33_done_fall");

        // 3x3 with an early mismatch at (1,0).
        fill(3'd6);
        mem[1][0] = 3'd4;
        begin_scan(5'd3, 3);
        wait_done(40, e);
        check("m10_done", DONE, 1);
        check("m10_won", WON, 0);
        check("m10_ref", REF_COLOR, 6);
        check("m10_order", order_err, 0);
`ifdef BOARD_SCAN_EARLY_EXIT_EN
        check("m10_count", MATCH_COUNT, 3);
        check("m10_latency_bound", (e <= 7), 1);
        check("m10_reads_bound", (reads <= 6), 1);
`else
        check("m10_count", MATCH_COUNT, 8);
        check("m10_latency", e, 12);
        check("m10_reads", reads, 9);
`endif
        end_scan("m10_done_fall");

        // Empty board.
        begin_scan(5'd0, 0);
        wait_done(10, e);
        check("z_latency", e, 2);
        check("z_done", DONE, 1);
        check("z_won", WON, 1);
        check("z_count", MATCH_COUNT, 0);
        check("z_reads", reads, 0);
        end_scan("z_done_fall");

        // Oversized request clamps to 26x26.
        fill(3'd3);
        begin_scan(5'd31, 26);
        wait_done(800, e);
        check("big_latency", e, 679);
        check("big_reads", reads, 676);
        check("big_order", order_err, 0);
        check("big_last_row", last_r, 25);
        check("big_last_col", last_c, 25);
        check("big_won", WON, 1);
        check("big_count", MATCH_COUNT, 676);
        end_scan("big_done_fall");

        // Reset mid-scan, then a fresh scan.
        fill(3'd4);
        begin_scan(5'd10, 10);
        repeat (5) @(posedge CLOCK);
        #1;
        RESET_N = 1'b0;
        #1;
        check_idle_outputs("abort");
        START = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("abort_no_done", DONE, 0);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;
        begin_scan(5'd2, 2);
        wait_done(20, e);
        check("post_latency", e, 7);
        check("post_count", MATCH_COUNT, 4);
        check("post_won", WON, 1);
        check("post_ref", REF_COLOR, 4);
        end_scan("post_done_fall");

        // START dropped mid-scan and SIZE changed after acceptance.
        fill(3'd5);
        begin_scan(5'd4, 4);
        repeat (3) @(posedge CLOCK);
        #1;
        START = 1'b0;
        SIZE = 5'd1;
        wait_done(40, e);
        check("drop_latency", e + 3, 19);
        check("drop_done", DONE, 1);
        check("drop_count", MATCH_COUNT, 16);
        check("drop_reads", reads, 16);
        @(posedge CLOCK);
        #1;
        check("drop_done_fall", DONE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
